// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared state encodings, NOP and opcode constants for the fetch path
//
// Purpose: definitions shared by fetch_unit, its next-PC helper and control_unit.
// Ports:   none (package).
package fetch_unit_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_FAULT = 3'd4
    } fetch_state_t;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // Plain 32-bit add; wrap-around modulo 2^32 is the intended behaviour.
    function automatic logic [31:0] pc_add(input logic [31:0] a, input logic [31:0] b);
        return a + b;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction memory read bus between fetch_unit and memory
//
// Purpose: bundles the instruction-memory request/response signals.
// Signals: imemReq (1-cycle read request), imemAddr (read address),
//          imemValid (response valid), imemRdata (instruction word).
// Modports: master = fetch side, slave = memory side.
interface fetch_unit_if;

    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemValid;
    logic [31:0] imemRdata;

    modport master (
        output imemReq,
        output imemAddr,
        input  imemValid,
        input  imemRdata
    );

    modport slave (
        input  imemReq,
        input  imemAddr,
        output imemValid,
        output imemRdata
    );

endinterface

// File: rtl/fetch_unit_next_pc_calc.sv
// rtl/fetch_unit_next_pc_calc.sv - combinational next-PC selection and misalignment flag
//
// Purpose: computes the PC that follows the presented instruction.
// Ports:   i_pc, i_imm (32b), i_branch, i_jump, i_branch_taken (decode/ALU flags)
//          o_next_pc (selected target), o_pc_plus4 (sequential PC), o_misaligned.
module fetch_unit_next_pc_calc
    import fetch_unit_pkg::*;
(
    input  logic [31:0] i_pc,
    input  logic [31:0] i_imm,
    input  logic        i_branch,
    input  logic        i_jump,
    input  logic        i_branch_taken,
    output logic [31:0] o_next_pc,
    output logic [31:0] o_pc_plus4,
    output logic        o_misaligned
);

    logic w_take;

    // A jump is taken unconditionally, even when branch is also flagged.
    assign w_take       = i_jump | (i_branch & i_branch_taken);
    assign o_pc_plus4   = pc_add(i_pc, 32'd4);
    assign o_next_pc    = w_take ? pc_add(i_pc, i_imm) : o_pc_plus4;
    assign o_misaligned = |o_next_pc[1:0];

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - single-outstanding instruction fetch FSM with branch/jump redirect
//
// Purpose: fetches one instruction at a time, presents it until accepted,
//          then redirects or advances the PC; faults stickily on a misaligned
//          target or a memory response timeout.
// Ports:   clk, reset (sync, active-high)
//          imem        instruction memory bus (master side)
//          instruction, pc, pcPlus4, instrValid   presented instruction
//          instrAccept, stall                     downstream handshake
//          branch, jump, branchTaken, imm         redirect information
//          fetchFault                             sticky fault flag
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          MAX_WAIT     = 16
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master imem,
    output logic [31:0]  instruction,
    output logic [31:0]  pc,
    output logic [31:0]  pcPlus4,
    output logic         instrValid,
    input  logic         instrAccept,
    input  logic         stall,
    input  logic         branch,
    input  logic         jump,
    input  logic         branchTaken,
    input  logic [31:0]  imm,
    output logic         fetchFault
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

    fetch_state_t     r_state;
    fetch_state_t     w_next_state;
    logic [31:0]      r_pc;
    logic [31:0]      r_instr;
    logic [CNT_W-1:0] r_wait_cnt;

    logic [31:0]      w_next_pc;
    logic [31:0]      w_pc_plus4;
    logic             w_misaligned;
    logic             w_pc_load;
    logic             w_instr_load;
    logic             w_cnt_clr;
    logic             w_cnt_inc;

    fetch_unit_next_pc_calc u_next_pc (
        .i_pc           (r_pc),
        .i_imm          (imm),
        .i_branch       (branch),
        .i_jump         (jump),
        .i_branch_taken (branchTaken),
        .o_next_pc      (w_next_pc),
        .o_pc_plus4     (w_pc_plus4),
        .o_misaligned   (w_misaligned)
    );

    always_comb begin
        w_next_state = r_state;
        w_pc_load    = 1'b0;
        w_instr_load = 1'b0;
        w_cnt_clr    = 1'b0;
        w_cnt_inc    = 1'b0;
        case (r_state)
            ST_IDLE: w_next_state = ST_REQ;
            ST_REQ: begin
                w_cnt_clr    = 1'b1;
                w_next_state = ST_WAIT;
            end
            ST_WAIT: begin
                // imemValid is only looked at here, so responses arriving in
                // any other state are dropped.
                if (imem.imemValid) begin
                    w_instr_load = 1'b1;
                    w_next_state = ST_HOLD;
                end else if (r_wait_cnt == CNT_LAST) begin
                    w_next_state = ST_FAULT;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            ST_HOLD: begin
                // stall overrides instrAccept; a misaligned target leaves pc
                // pointing at the offending instruction.
                if (instrAccept && !stall) begin
                    if (w_misaligned) begin
                        w_next_state = ST_FAULT;
                    end else begin
                        w_pc_load    = 1'b1;
                        w_next_state = ST_REQ;
                    end
                end
            end
            ST_FAULT: w_next_state = ST_FAULT;
            default:  w_next_state = ST_FAULT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_pc       <= RESET_VECTOR;
            r_instr    <= NOP_INSTR;
            r_wait_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_pc_load) begin
                r_pc <= w_next_pc;
            end
            if (w_instr_load) begin
                r_instr <= imem.imemRdata;
            end
            if (w_cnt_clr) begin
                r_wait_cnt <= '0;
            end else if (w_cnt_inc) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
        end
    end

    assign imem.imemReq  = (r_state == ST_REQ);
    assign imem.imemAddr = r_pc;
    assign instruction   = r_instr;
    assign pc            = r_pc;
    assign pcPlus4       = w_pc_plus4;
    assign instrValid    = (r_state == ST_HOLD);
    assign fetchFault    = (r_state == ST_FAULT);

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking testbench for fetch_unit
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam int          MW = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instruction, pc, pcPlus4, imm;
    logic        instrValid, instrAccept, stall, branch, jump, branchTaken, fetchFault;

    fetch_unit_if imem_bus ();

    fetch_unit #(.RESET_VECTOR(RV), .MAX_WAIT(MW)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem        (imem_bus),
        .instruction (instruction),
        .pc          (pc),
        .pcPlus4     (pcPlus4),
        .instrValid  (instrValid),
        .instrAccept (instrAccept),
        .stall       (stall),
        .branch      (branch),
        .jump        (jump),
        .branchTaken (branchTaken),
        .imm         (imm),
        .fetchFault  (fetchFault)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] obs_q[$];
    bit          mem_en = 1'b1;
    bit          inject = 1'b0;

    typedef struct {
        logic        br;
        logic        jp;
        logic        tk;
        logic [31:0] im;
        logic [31:0] nxt;
    } vec_t;
    vec_t vecs[9];

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'h0050_0093;
    endfunction

    // memory model: answers one cycle after a request, records every request
    initial begin
        bit          pending;
        logic [31:0] pend_addr;
        pending = 1'b0;
        pend_addr = '0;
        imem_bus.imemValid = 1'b0;
        imem_bus.imemRdata = '0;
        forever begin
            @(negedge clk);
            #1;
            if (inject) begin
                imem_bus.imemValid = 1'b1;
                imem_bus.imemRdata = 32'hDEAD_BEEF;
                pending = 1'b0;
            end else if (pending) begin
                imem_bus.imemValid = 1'b1;
                imem_bus.imemRdata = mem_data(pend_addr);
                pending = 1'b0;
            end else begin
                imem_bus.imemValid = 1'b0;
                imem_bus.imemRdata = '0;
            end
            if (imem_bus.imemReq === 1'b1) begin
                obs_q.push_back(imem_bus.imemAddr);
                if (mem_en) begin
                    pending = 1'b1;
                    pend_addr = imem_bus.imemAddr;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drain();
        logic [31:0] o;
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_req: got %h expected none", o);
            end else begin
                check("req_addr", o, exp_q.pop_front());
            end
        end
    endtask

    task automatic wait_hold(output int n);
        n = 0;
        while (instrValid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("hold_reached", {31'd0, instrValid}, 32'd1);
    endtask

    task automatic accept(input logic b, input logic j, input logic t, input logic [31:0] i);
        branch = b; jump = j; branchTaken = t; imm = i; instrAccept = 1'b1;
        @(negedge clk);
        instrAccept = 1'b0; branch = 1'b0; jump = 1'b0; branchTaken = 1'b0; imm = '0;
    endtask

    initial begin
        int          n;
        logic [31:0] cur;

        vecs[0] = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0004};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h0000_000C, 32'h0000_0010};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8, 32'h0000_0008};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 32'h0000_0008, 32'h0000_0010};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'h0000_0014};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 32'h0000_0020, 32'h0000_0034};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 32'hFFFF_FFC8, 32'hFFFF_FFFC};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000};
        vecs[8] = '{1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0000_0100};

        reset = 1'b1; instrAccept = 1'b0; stall = 1'b0;
        branch = 1'b0; jump = 1'b0; branchTaken = 1'b0; imm = '0;
        repeat (2) @(negedge clk);
        check("rst_pc", pc, RV);
        check("rst_instr", instruction, NOP_INSTR);
        check("rst_valid", {31'd0, instrValid}, 32'd0);
        check("rst_req", {31'd0, imem_bus.imemReq}, 32'd0);
        check("rst_fault", {31'd0, fetchFault}, 32'd0);

        exp_q.push_back(RV);
        reset = 1'b0;
        n = 0;
        while (instrValid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("fetch_latency", n, 32'd3);
        drain();

        cur = RV;
        for (int i = 0; i < 9; i++) begin
            check("hold_pc", pc, cur);
            check("hold_pc4", pcPlus4, cur + 32'd4);
            check("hold_instr", instruction, mem_data(cur));
            exp_q.push_back(vecs[i].nxt);
            accept(vecs[i].br, vecs[i].jp, vecs[i].tk, vecs[i].im);
            cur = vecs[i].nxt;
            wait_hold(n);
            drain();
        end
        check("table_end_pc", pc, 32'h0000_0100);

        // stall overrides accept for 5 cycles, then a single advance
        stall = 1'b1;
        instrAccept = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_pc", pc, 32'h0000_0100);
            check("stall_instr", instruction, mem_data(32'h0000_0100));
            check("stall_valid", {31'd0, instrValid}, 32'd1);
            check("stall_noreq", obs_q.size(), 32'd0);
        end
        exp_q.push_back(32'h0000_0104);
        stall = 1'b0;
        @(negedge clk);
        instrAccept = 1'b0;
        wait_hold(n);
        drain();
        check("stall_release_pc", pc, 32'h0000_0104);
        check("stall_single_adv", exp_q.size(), 32'd0);

        exp_q.push_back(32'h0000_0100);
        accept(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC);
        wait_hold(n);
        drain();

        // misaligned jump target
        accept(1'b0, 1'b1, 1'b0, 32'h0000_0006);
        check("mis_fault", {31'd0, fetchFault}, 32'd1);
        check("mis_pc", pc, 32'h0000_0100);
        check("mis_valid", {31'd0, instrValid}, 32'd0);
        repeat (20) @(negedge clk);
        check("mis_noreq", obs_q.size(), 32'd0);
        check("mis_sticky", {31'd0, fetchFault}, 32'd1);

        // memory never answers
        reset = 1'b1;
        mem_en = 1'b0;
        @(negedge clk);
        check("to_rst_fault", {31'd0, fetchFault}, 32'd0);
        exp_q.push_back(RV);
        reset = 1'b0;
        n = 0;
        while (fetchFault !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("timeout_cycles", n, MW + 2);
        check("timeout_valid", {31'd0, instrValid}, 32'd0);
        drain();

        // reset lands mid-WAIT while a late response is on the bus
        reset = 1'b1;
        @(negedge clk);
        exp_q.push_back(RV);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("midwait_valid", {31'd0, instrValid}, 32'd0);
        reset = 1'b1;
        inject = 1'b1;
        @(negedge clk);
        check("midwait_rst_instr", instruction, NOP_INSTR);
        exp_q.push_back(RV);
        reset = 1'b0;
        mem_en = 1'b1;
        @(negedge clk);
        inject = 1'b0;
        wait_hold(n);
        drain();
        check("late_instr", instruction, mem_data(RV));
        check("late_pc", pc, RV);
        check("late_fault", {31'd0, fetchFault}, 32'd0);
        check("sb_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
